// File: rtl/duck_link_pkg.sv
// Shared definitions for the GPIO coordinate link (transmitter and receiver).
// Bus bit positions, link FSM state encoding and screen range constants.
package duck_link_pkg;

    localparam int DATA_LSB   = 0;
    localparam int DATA_W     = 9;
    localparam int FSTART_BIT = 9;
    localparam int WSEL_BIT   = 10;
    localparam int STROBE_BIT = 11;
    localparam int SHOT_BIT   = 12;
    localparam int PAR_BIT    = 13;
    localparam int GPIO_W     = 36;

    localparam int X_RANGE = 320;
    localparam int Y_RANGE = 240;

    typedef enum logic [2:0] {
        LS_IDLE     = 3'd0,
        LS_SETUP_X  = 3'd1,
        LS_STROBE_X = 3'd2,
        LS_GAP      = 3'd3,
        LS_SETUP_Y  = 3'd4,
        LS_STROBE_Y = 3'd5
    } link_state_t;

    // Odd parity: the returned bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [10:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/coord_link_tx_if.sv
// Sample handshake between the coordinate source and the link transmitter.
interface coord_link_tx_if;
    logic       send_valid;
    logic       send_ready;
    logic [8:0] cursor_x;
    logic [8:0] cursor_y;
    logic       shot;

    modport master (output send_valid, output cursor_x, output cursor_y, output shot,
                    input  send_ready);
    modport slave  (input  send_valid, input  cursor_x, input  cursor_y, input  shot,
                    output send_ready);
endinterface

// File: rtl/link_dwell_timer.sv
// Loadable 8-bit down-counter that parks at zero; sets the dwell time of each link state.
module link_dwell_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic       o_zero
);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/coord_link_tx.sv
// Coordinate link transmitter: serialises X/Y/shot as two strobed 9-bit words on GPIO_OUT.
// Optional build macro COORD_LINK_PARITY_EN drives odd parity on GPIO_OUT[13].
module coord_link_tx
    import duck_link_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = 4,
    parameter int unsigned STROBE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES    = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    coord_link_tx_if.slave    link,
    output logic [GPIO_W-1:0] GPIO_OUT,
    output logic              frame_done
);

    localparam logic [2:0] S_IDLE     = 3'(LS_IDLE);
    localparam logic [2:0] S_SETUP_X  = 3'(LS_SETUP_X);
    localparam logic [2:0] S_STROBE_X = 3'(LS_STROBE_X);
    localparam logic [2:0] S_GAP      = 3'(LS_GAP);
    localparam logic [2:0] S_SETUP_Y  = 3'(LS_SETUP_Y);
    localparam logic [2:0] S_STROBE_Y = 3'(LS_STROBE_Y);

    localparam logic [7:0] SETUP_M1  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_M1 = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] GAP_M1    = 8'(GAP_CYCLES - 1);

    logic [2:0]        r_state;
    logic [8:0]        r_x;
    logic [8:0]        r_y;
    logic              r_shot;
    logic [GPIO_W-1:0] r_gpio;
    logic              r_frame_done;
    logic              r_send_ready;

    logic [2:0]        w_state_next;
    logic              w_transfer;
    logic              w_load;
    logic [7:0]        w_load_val;
    logic              w_zero;
    logic [8:0]        w_src_x;
    logic              w_src_shot;
    logic              w_word_y;
    logic [8:0]        w_data;
    logic [GPIO_W-1:0] w_bus_next;

    assign w_transfer = link.send_valid && (r_state == S_IDLE);

    link_dwell_timer u_dwell (
        .clk        (Clk),
        .rst_n      (Reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // Every state change reloads the dwell counter with the next state's length minus one.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_val   = 8'd0;
        case (r_state)
            S_IDLE: if (w_transfer) begin
                w_state_next = S_SETUP_X;  w_load = 1'b1; w_load_val = SETUP_M1;
            end
            S_SETUP_X: if (w_zero) begin
                w_state_next = S_STROBE_X; w_load = 1'b1; w_load_val = STROBE_M1;
            end
            S_STROBE_X: if (w_zero) begin
                w_state_next = S_GAP;      w_load = 1'b1; w_load_val = GAP_M1;
            end
            S_GAP: if (w_zero) begin
                w_state_next = S_SETUP_Y;  w_load = 1'b1; w_load_val = SETUP_M1;
            end
            S_SETUP_Y: if (w_zero) begin
                w_state_next = S_STROBE_Y; w_load = 1'b1; w_load_val = STROBE_M1;
            end
            S_STROBE_Y: if (w_zero) begin
                w_state_next = S_IDLE;     w_load = 1'b1; w_load_val = 8'd0;
            end
            default: begin
                w_state_next = S_IDLE;     w_load = 1'b1; w_load_val = 8'd0;
            end
        endcase
    end

    // The bus is built from the next state so it appears one cycle after the transfer edge.
    always_comb begin
        w_src_x    = w_transfer ? link.cursor_x : r_x;
        w_src_shot = w_transfer ? link.shot     : r_shot;
        w_word_y   = (w_state_next == S_SETUP_Y) || (w_state_next == S_STROBE_Y);
        w_data     = w_word_y ? r_y : w_src_x;
        w_bus_next = '0;
        if (w_state_next != S_IDLE) begin
            w_bus_next[DATA_LSB +: DATA_W] = w_data;
            w_bus_next[FSTART_BIT] = (w_state_next == S_SETUP_X) || (w_state_next == S_STROBE_X);
            w_bus_next[WSEL_BIT]   = w_word_y;
            w_bus_next[STROBE_BIT] = (w_state_next == S_STROBE_X) || (w_state_next == S_STROBE_Y);
            w_bus_next[SHOT_BIT]   = w_src_shot;
`ifdef COORD_LINK_PARITY_EN
            w_bus_next[PAR_BIT]    = odd_parity({w_word_y, w_src_shot, w_data});
`endif
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= S_IDLE;
            r_x          <= 9'd0;
            r_y          <= 9'd0;
            r_shot       <= 1'b0;
            r_gpio       <= '0;
            r_frame_done <= 1'b0;
            r_send_ready <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_gpio       <= w_bus_next;
            r_frame_done <= (r_state == S_STROBE_Y) && w_zero;
            r_send_ready <= (w_state_next == S_IDLE);
            if (w_transfer) begin
                r_x    <= link.cursor_x;
                r_y    <= link.cursor_y;
                r_shot <= link.shot;
            end
        end
    end

    assign GPIO_OUT       = r_gpio;
    assign frame_done     = r_frame_done;
    assign link.send_ready = r_send_ready;

endmodule

// File: tb/tb_coord_link_tx.sv
// Bench for coord_link_tx: two instances with different dwell settings, checked against a
// timeline model of the frame; honours COORD_LINK_PARITY_EN for the parity expectations.
module tb_coord_link_tx;

    localparam int NI = 2;

    logic Clk = 1'b0;
    always #10 Clk = ~Clk;

    logic                 Reset;
    logic [NI-1:0]        v_d;
    logic [NI-1:0][8:0]   x_d;
    logic [NI-1:0][8:0]   y_d;
    logic [NI-1:0]        s_d;
    logic [NI-1:0]        rdy;
    logic [NI-1:0][35:0]  gpio;
    logic [NI-1:0]        fd;

    int checks   = 0;
    int failures = 0;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            coord_link_tx_if lk ();
            assign lk.send_valid = v_d[gi];
            assign lk.cursor_x   = x_d[gi];
            assign lk.cursor_y   = y_d[gi];
            assign lk.shot       = s_d[gi];
            assign rdy[gi]       = lk.send_ready;
            coord_link_tx #(
                .SETUP_CYCLES  (gi == 0 ? 2 : 5),
                .STROBE_CYCLES (gi == 0 ? 3 : 1),
                .GAP_CYCLES    (gi == 0 ? 2 : 3)
            ) u_dut (
                .Clk        (Clk),
                .Reset      (Reset),
                .link       (lk),
                .GPIO_OUT   (gpio[gi]),
                .frame_done (fd[gi])
            );
        end
    endgenerate

    function automatic int p_s(int i); return (i == 0) ? 2 : 5; endfunction
    function automatic int p_t(int i); return (i == 0) ? 3 : 1; endfunction
    function automatic int p_g(int i); return (i == 0) ? 2 : 3; endfunction
    function automatic int frame_len(int i); return 2 * p_s(i) + 2 * p_t(i) + p_g(i); endfunction

    // Expected bus k cycles after the transfer edge (k = 1 is the first X cycle).
    function automatic logic [35:0] exp_bus(int i, int k, logic [8:0] x, logic [8:0] y, logic s);
        int S = p_s(i);
        int T = p_t(i);
        int G = p_g(i);
        logic [35:0] b;
        logic [8:0]  d;
        logic        w;
        b = '0;
        if (k >= 1 && k <= 2 * S + 2 * T + G) begin
            if (k <= S + T + G) begin d = x; w = 1'b0; end
            else                begin d = y; w = 1'b1; end
            b[8:0] = d;
            b[9]   = (k <= S + T);
            b[10]  = w;
            b[11]  = ((k > S) && (k <= S + T)) || (k > S + T + G + S);
            b[12]  = s;
`ifdef COORD_LINK_PARITY_EN
            b[13]  = ~^{w, s, d};
`endif
        end
        return b;
    endfunction

    task automatic test_reset();
        Reset = 1'b0;
        v_d = '0; x_d = '0; y_d = '0; s_d = '0;
        repeat (3) @(negedge Clk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (gpio[i] !== 36'd0 || fd[i] !== 1'b0)
                $display("FAIL reset_outputs inst=%0d gpio=%h fd=%b expected gpio=0 fd=0", i, gpio[i], fd[i]);
            if (gpio[i] !== 36'd0 || fd[i] !== 1'b0) failures++;
        end
        Reset = 1'b1;
        @(negedge Clk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (rdy[i] !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready inst=%0d ready=%b expected 1", i, rdy[i]);
            end
        end
        $display("reset: released, both instances idle");
    endtask

    task automatic test_single_frame();
        int L = frame_len(0);
        int strobe_x = 0, strobe_y = 0, shot_cnt = 0, done_k = -1;
        logic [35:0] eb;
        @(negedge Clk);
        checks++;
        if (rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL single_ready ready=%b expected 1", rdy[0]);
        end
        v_d[0] = 1'b1; x_d[0] = 9'h13F; y_d[0] = 9'h0EF; s_d[0] = 1'b1;
        @(negedge Clk);
        v_d[0] = 1'b0; x_d[0] = 9'h000; y_d[0] = 9'h000; s_d[0] = 1'b0;
        for (int k = 1; k <= L + 3; k++) begin
            eb = exp_bus(0, k, 9'h13F, 9'h0EF, 1'b1);
            checks++;
            if (gpio[0] !== eb) begin
                failures++;
                $display("FAIL single_bus k=%0d gpio=%h expected %h", k, gpio[0], eb);
            end
            if (gpio[0][11] && !gpio[0][10]) strobe_x++;
            if (gpio[0][11] &&  gpio[0][10]) strobe_y++;
            if (gpio[0][12]) shot_cnt++;
            if (fd[0] === 1'b1) done_k = k;
            @(negedge Clk);
        end
        checks++;
        if (strobe_x != 3 || strobe_y != 3) begin
            failures++;
            $display("FAIL single_strobe_len x=%0d y=%0d expected 3 and 3", strobe_x, strobe_y);
        end
        checks++;
        if (done_k != 13) begin
            failures++;
            $display("FAIL single_frame_done cycle=%0d expected 13", done_k);
        end
        checks++;
        if (shot_cnt != L) begin
            failures++;
            $display("FAIL single_shot cycles=%0d expected %0d", shot_cnt, L);
        end
        $display("single: x=13f y=0ef shot=1 frame_done at cycle %0d", done_k);
    endtask

    task automatic test_busy();
        int L = frame_len(0);
        int tcyc[$];
        bit active = 0, go = 0;
        int k = 0;
        logic [8:0] cx = 0, cy = 0, nx = 0, ny = 0;
        logic cs = 0, ns = 0;
        logic [35:0] eb;
        logic ed, er;
        for (int c = 0; c < 45; c++) begin
            @(negedge Clk);
            if (go) begin
                active = 1; k = 1; cx = nx; cy = ny; cs = ns;
                tcyc.push_back(c);
                $display("busy: frame accepted x=%h y=%h shot=%b at cycle %0d", cx, cy, cs, c);
            end else if (active) begin
                k++;
                if (k > L + 1) active = 0;
            end
            eb = active ? exp_bus(0, k, cx, cy, cs) : 36'd0;
            ed = active && (k == L + 1);
            er = !active || (k >= L + 1);
            checks++;
            if (gpio[0] !== eb) begin
                failures++;
                $display("FAIL busy_bus cycle=%0d gpio=%h expected %h", c, gpio[0], eb);
            end
            checks++;
            if (fd[0] !== ed) begin
                failures++;
                $display("FAIL busy_frame_done cycle=%0d fd=%b expected %b", c, fd[0], ed);
            end
            checks++;
            if (rdy[0] !== er) begin
                failures++;
                $display("FAIL busy_ready cycle=%0d ready=%b expected %b", c, rdy[0], er);
            end
            nx = 9'($urandom_range(0, 511));
            ny = 9'($urandom_range(0, 511));
            ns = 1'($urandom_range(0, 1));
            x_d[0] = nx; y_d[0] = ny; s_d[0] = ns; v_d[0] = 1'b1;
            go = er;
        end
        v_d[0] = 1'b0;
        repeat (L + 2) @(negedge Clk);
        checks++;
        if (tcyc.size() < 3) begin
            failures++;
            $display("FAIL busy_transfers count=%0d expected at least 3", tcyc.size());
        end
        for (int j = 1; j < tcyc.size(); j++) begin
            checks++;
            if (tcyc[j] - tcyc[j-1] != 13) begin
                failures++;
                $display("FAIL busy_period got=%0d expected 13", tcyc[j] - tcyc[j-1]);
            end
        end
    endtask

    task automatic test_setup_hold();
        logic [9:0] prev[NI];
        logic       pst[NI];
        int         stab[NI];
        int         rises[NI];
        logic [9:0] cur;
        for (int i = 0; i < NI; i++) begin
            prev[i] = '0; pst[i] = 1'b0; stab[i] = 1; rises[i] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            @(negedge Clk);
            for (int i = 0; i < NI; i++) begin
                cur = {gpio[i][10], gpio[i][8:0]};
                stab[i] = (cur == prev[i]) ? stab[i] + 1 : 1;
                if (gpio[i][11] && pst[i]) begin
                    checks++;
                    if (cur !== prev[i]) begin
                        failures++;
                        $display("FAIL hold inst=%0d wsel_data=%h expected %h", i, cur, prev[i]);
                    end
                end
                if (gpio[i][11] && !pst[i]) begin
                    rises[i]++;
                    checks++;
                    if (stab[i] - 1 < p_s(i)) begin
                        failures++;
                        $display("FAIL setup inst=%0d stable=%0d expected >= %0d", i, stab[i] - 1, p_s(i));
                    end
                end
                prev[i] = cur;
                pst[i]  = gpio[i][11];
                v_d[i] = 1'($urandom_range(0, 1));
                x_d[i] = 9'($urandom_range(0, 511));
                y_d[i] = 9'($urandom_range(0, 511));
                s_d[i] = 1'($urandom_range(0, 1));
            end
        end
        v_d = '0;
        repeat (40) @(negedge Clk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (rises[i] < 4) begin
                failures++;
                $display("FAIL setup_hold_activity inst=%0d rises=%0d expected at least 4", i, rises[i]);
            end
            $display("setup_hold: inst=%0d strobe rises=%0d", i, rises[i]);
        end
    endtask

    task automatic test_parity();
        int L = frame_len(0);
`ifdef COORD_LINK_PARITY_EN
        logic [8:0] xs[2];
        logic       ep[2];
        xs[0] = 9'h000; ep[0] = 1'b1;
        xs[1] = 9'h001; ep[1] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            @(negedge Clk);
            v_d[0] = 1'b1; x_d[0] = xs[n]; y_d[0] = 9'($urandom_range(0, 511)); s_d[0] = 1'b0;
            @(negedge Clk);
            v_d[0] = 1'b0;
            checks++;
            if (gpio[0][13] !== ep[n]) begin
                failures++;
                $display("FAIL parity x=%h bit13=%b expected %b", xs[n], gpio[0][13], ep[n]);
            end
            $display("parity: x=%h shot=0 bit13=%b", xs[n], gpio[0][13]);
            repeat (L + 1) @(negedge Clk);
        end
`else
        @(negedge Clk);
        v_d[0] = 1'b1; x_d[0] = 9'h000; y_d[0] = 9'h0AA; s_d[0] = 1'b0;
        @(negedge Clk);
        v_d[0] = 1'b0;
        for (int k = 1; k <= L + 1; k++) begin
            checks++;
            if (gpio[0][13] !== 1'b0) begin
                failures++;
                $display("FAIL parity_off k=%0d bit13=%b expected 0", k, gpio[0][13]);
            end
            @(negedge Clk);
        end
        $display("parity: disabled build, bit13 held 0");
`endif
    endtask

    task automatic test_midframe_reset();
        int S = p_s(0);
        int L = frame_len(0);
        logic [8:0] x, y;
        logic s;
        logic [35:0] eb;
        @(negedge Clk);
        v_d[0] = 1'b1; x_d[0] = 9'h1A5; y_d[0] = 9'h05A; s_d[0] = 1'b1;
        @(negedge Clk);
        v_d[0] = 1'b0;
        repeat (S + 1) @(negedge Clk);
        checks++;
        if (gpio[0][11] !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre strobe=%b expected 1", gpio[0][11]);
        end
        #3 Reset = 1'b0;
        #1;
        checks++;
        if (gpio[0] !== 36'd0 || fd[0] !== 1'b0) begin
            failures++;
            $display("FAIL midreset_drop gpio=%h fd=%b expected gpio=0 fd=0", gpio[0], fd[0]);
        end
        @(negedge Clk);
        Reset = 1'b1;
        for (int c = 0; c < 2 * L; c++) begin
            @(negedge Clk);
            checks++;
            if (gpio[0] !== 36'd0 || fd[0] !== 1'b0 || rdy[0] !== 1'b1) begin
                failures++;
                $display("FAIL midreset_no_y cycle=%0d gpio=%h fd=%b ready=%b expected 0 0 1", c, gpio[0], fd[0], rdy[0]);
            end
        end
        x = 9'($urandom_range(0, 511));
        y = 9'($urandom_range(0, 511));
        s = 1'($urandom_range(0, 1));
        v_d[0] = 1'b1; x_d[0] = x; y_d[0] = y; s_d[0] = s;
        @(negedge Clk);
        v_d[0] = 1'b0;
        for (int k = 1; k <= L + 1; k++) begin
            eb = exp_bus(0, k, x, y, s);
            checks++;
            if (gpio[0] !== eb || fd[0] !== (k == L + 1)) begin
                failures++;
                $display("FAIL midreset_next k=%0d gpio=%h fd=%b expected %h %b", k, gpio[0], fd[0], eb, (k == L + 1));
            end
            @(negedge Clk);
        end
        $display("midreset: next frame x=%h y=%h shot=%b after release", x, y, s);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_busy();
        test_setup_hold();
        test_parity();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
